// File: rtl/apb_requester_arbiter_if.sv
// apb_requester_arbiter_if
// Bundles the local command/response channels and the APB4 requester bus.
// The master modport is the arbiter's view. The slave modport is the
// environment's view: command sources, response sinks and the APB completer.
interface apb_requester_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Local command sources, one slice per source
    logic [NUM_REQ-1:0]              cmd_valid;
    logic [NUM_REQ-1:0]              cmd_ready;
    logic [NUM_REQ-1:0]              cmd_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   cmd_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]   cmd_wdata;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] cmd_strb;
    logic [NUM_REQ*3-1:0]            cmd_prot;

    // Shared response channel, qualified per source by rsp_valid
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]           rsp_rdata;
    logic                            rsp_slverr;

    // APB4 requester bus
    logic [ADDR_WIDTH-1:0]           paddr;
    logic [2:0]                      pprot;
    logic                            pnse;
    logic                            psel;
    logic                            penable;
    logic                            pwrite;
    logic [DATA_WIDTH-1:0]           pwdata;
    logic [DATA_WIDTH/8-1:0]         pstrb;
    logic                            pready;
    logic [DATA_WIDTH-1:0]           prdata;
    logic                            pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr,
        output paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr,
        input  paddr, pprot, pnse, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_requester_arbiter.sv
// apb_requester_arbiter
// Round-robin arbiter that shares one APB4 requester port between NUM_REQ
// local command sources. Each accepted command runs through the SETUP and
// ACCESS phases. The completer's response is then returned as a one-cycle
// pulse to the source that issued the command.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without pready. The abort answers with slverr=1.
module apb_requester_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   pclk,
    input  logic                   preset,
    apb_requester_arbiter_if.master bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;

    // Reject unsupported configurations at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("apb_requester_arbiter: NUM_REQ must be 2..16");
    end
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb_requester_arbiter: DATA_WIDTH must be 8, 16 or 32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_requester_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_ptr;
    logic [PW-1:0]          r_owner;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic [SW-1:0]          r_pstrb;
    logic [2:0]             r_pprot;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic                   r_rsp_slverr;

    // Per-source views of the packed command buses
    logic [ADDR_WIDTH-1:0]  w_src_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  w_src_wdata [NUM_REQ];
    logic [SW-1:0]          w_src_strb  [NUM_REQ];
    logic [2:0]             w_src_prot  [NUM_REQ];
    logic [NUM_REQ-1:0]     w_ready;
    logic [NUM_REQ-1:0]     w_owner_hot;

    logic [PW-1:0]          w_grant;
    logic                   w_any;
    logic                   w_accept;
    logic [PW-1:0]          w_ptr_next;
    logic                   w_sel_write;
    logic                   w_timeout;

    // Round-robin search: first set cmd_valid at or above r_ptr, wrapping.
    // Iterating from the far end lets the closest request overwrite the rest.
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        w_any   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (bus.cmd_valid[PW'(idx)]) begin
                w_grant = PW'(idx);
                w_any   = 1'b1;
            end
        end
    end

    // Commands are only taken in IDLE. Holding reset also blocks cmd_ready so
    // that no source sees an accept while the block is being reset.
    assign w_accept    = (r_state == ST_IDLE) && w_any && !preset;
    assign w_ptr_next  = (w_grant == PW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
    assign w_sel_write = bus.cmd_write[w_grant];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
        assign w_src_addr[gi]  = bus.cmd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_src_wdata[gi] = bus.cmd_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_src_strb[gi]  = bus.cmd_strb[gi*SW +: SW];
        assign w_src_prot[gi]  = bus.cmd_prot[gi*3 +: 3];
        assign w_ready[gi]     = w_accept && (w_grant == PW'(gi));
        assign w_owner_hot[gi] = (r_owner == PW'(gi));
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] r_tcnt;

    // Count ACCESS cycles without pready. Clearing in SETUP means the counter
    // starts from zero on every entry to ACCESS.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_tcnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_tcnt <= '0;
        end else if (r_state == ST_ACCESS && !bus.pready) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // The counter holds N-1 during the Nth ACCESS cycle. A pready in the last
    // allowed cycle therefore still completes normally.
    assign w_timeout = (r_state == ST_ACCESS) && !bus.pready &&
                       (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Transfer sequencer: accept in IDLE, drive SETUP, then ACCESS until done
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_owner      <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
            r_pprot      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
        end else begin
            // The response is a single-cycle pulse; its data is zero otherwise
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state  <= ST_SETUP;
                        r_psel   <= 1'b1;
                        r_owner  <= w_grant;
                        r_ptr    <= w_ptr_next;
                        r_pwrite <= w_sel_write;
                        r_paddr  <= w_src_addr[w_grant];
                        r_pwdata <= w_src_wdata[w_grant];
                        r_pprot  <= w_src_prot[w_grant];
                        // Reads never carry byte strobes on APB4
                        r_pstrb  <= w_sel_write ? w_src_strb[w_grant] : '0;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (bus.pready || w_timeout) begin
                        r_state      <= ST_IDLE;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_rsp_valid  <= w_owner_hot;
                        r_rsp_rdata  <= (bus.pready && !r_pwrite) ? bus.prdata : '0;
                        r_rsp_slverr <= bus.pready ? bus.pslverr : 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = w_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_slverr = r_rsp_slverr;
    assign bus.paddr      = r_paddr;
    assign bus.pprot      = r_pprot;
    assign bus.pnse       = 1'b0;
    assign bus.psel       = r_psel;
    assign bus.penable    = r_penable;
    assign bus.pwrite     = r_pwrite;
    assign bus.pwdata     = r_pwdata;
    assign bus.pstrb      = r_pstrb;
endmodule

// File: tb/tb_apb_requester_arbiter.sv
// tb_apb_requester_arbiter
// Directed bench for apb_requester_arbiter. Expected responses are queued at
// command accept and checked by an independent response monitor. A simple
// completer model answers APB transfers after a configurable number of waits.
// Build with APB_ARB_TIMEOUT_EN defined to also exercise the timeout abort.
module tb_apb_requester_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic pclk = 1'b0;
    logic preset;

    always #5 pclk = ~pclk;

    apb_requester_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_requester_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NR-1:0] hot;
        logic [31:0]   rdata;
        logic          slverr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cfg_waits = 0;
    logic [31:0] cfg_rdata = 32'h0;
    logic        cfg_slverr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Completer model: pready after cfg_waits wait states in ACCESS
    initial begin
        int acc;
        acc = 0;
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (bus.psel && bus.penable) begin
                bus.pready = (acc >= cfg_waits);
                acc++;
            end else begin
                bus.pready = 1'b0;
                acc = 0;
            end
            bus.prdata  = cfg_rdata;
            bus.pslverr = cfg_slverr && bus.pready;
        end
    end

    // Response monitor: pops one expectation per rsp_valid pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (bus.rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.hot));
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_slverr", 32'(bus.rsp_slverr), 32'(e.slverr));
                    $display("rsp  hot=%b rdata=%h slverr=%b t=%0t",
                             bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr, $time);
                end
            end
        end
    end

    // Present one command and wait (bounded) for its accept; returns at T+1
    task automatic issue(input int src, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot, input logic [31:0] exp_rdata,
                         input logic exp_slverr, input bit expect_rsp);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(negedge pclk);
        bus.cmd_write[src]           = wr;
        bus.cmd_addr[src*AW +: AW]   = addr;
        bus.cmd_wdata[src*DW +: DW]  = wdata;
        bus.cmd_strb[src*4 +: 4]     = strb;
        bus.cmd_prot[src*3 +: 3]     = prot;
        bus.cmd_valid[src]           = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.cmd_ready[src]) begin
                got = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        chk("accept_hot", 32'(bus.cmd_ready), 32'(1) << src);
        if (got && expect_rsp) begin
            e.hot    = NR'(1 << src);
            e.rdata  = exp_rdata;
            e.slverr = exp_slverr;
            exp_q.push_back(e);
        end
        $display("cmd  src=%0d wr=%b addr=%h accepted=%0d t=%0t", src, wr, addr, got, $time);
        @(negedge pclk);
        bus.cmd_valid[src] = 1'b0;
    endtask

    // Number of consecutive cycles with penable high, bounded
    task automatic count_access(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (bus.penable) n++;
            else if (n > 0) break;
        end
    endtask

    initial begin
        int          n_acc;
        int          acc_n;
        int          last_c;
        exp_t        e;

        // Reset state, with every source requesting while reset is held
        preset        = 1'b1;
        bus.cmd_valid = '1;
        bus.cmd_write = '0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_psel", 32'(bus.psel), 32'h0);
        chk("rst_penable", 32'(bus.penable), 32'h0);
        chk("rst_paddr", bus.paddr, 32'h0);
        chk("rst_pstrb", 32'(bus.pstrb), 32'h0);
        chk("rst_pwrite", 32'(bus.pwrite), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        chk("rst_pnse", 32'(bus.pnse), 32'h0);
        bus.cmd_valid = '0;
        @(negedge pclk);
        preset = 1'b0;

        // Zero-wait write from source 0
        cfg_waits = 0; cfg_rdata = 32'h1111_2222; cfg_slverr = 1'b0;
        issue(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b101, 32'h0, 1'b0, 1'b1);
        chk("t1_psel_setup", 32'(bus.psel), 32'h1);
        chk("t1_pen_setup", 32'(bus.penable), 32'h0);
        chk("t1_paddr", bus.paddr, 32'h10);
        chk("t1_pwrite", 32'(bus.pwrite), 32'h1);
        chk("t1_pwdata", bus.pwdata, 32'hA5A5_0001);
        chk("t1_pstrb", 32'(bus.pstrb), 32'hF);
        chk("t1_pprot", 32'(bus.pprot), 32'h5);
        @(negedge pclk);
        chk("t1_psel_access", 32'(bus.psel), 32'h1);
        chk("t1_pen_access", 32'(bus.penable), 32'h1);
        @(negedge pclk);
        chk("t1_psel_done", 32'(bus.psel), 32'h0);
        chk("t1_rsp_at_t3", 32'(bus.rsp_valid), 32'h1);

        // Read from source 2 with three wait states
        cfg_waits = 3; cfg_rdata = 32'hDEAD_BEEF;
        issue(2, 1'b0, 32'h200, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("t2_pstrb_read", 32'(bus.pstrb), 32'h0);
        chk("t2_pwrite", 32'(bus.pwrite), 32'h0);
        chk("t2_paddr", bus.paddr, 32'h200);
        count_access(n_acc);
        chk("t2_access_cycles", 32'(n_acc), 32'd4);

        // Slave error on a write from source 1
        cfg_waits = 1; cfg_slverr = 1'b1; cfg_rdata = 32'h1234_5678;
        issue(1, 1'b1, 32'h44, 32'h0BAD_F00D, 4'h3, 3'b010, 32'h0, 1'b1, 1'b1);
        repeat (4) @(negedge pclk);
        cfg_slverr = 1'b0;

        // Reset during ACCESS: bus drops at once and no response follows
        cfg_waits = 1000;
        issue(1, 1'b0, 32'h80, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0);
        @(negedge pclk);
        chk("t4_in_access", 32'(bus.penable), 32'h1);
        #2 preset = 1'b1;
        #1;
        chk("t4_psel_async", 32'(bus.psel), 32'h0);
        chk("t4_pen_async", 32'(bus.penable), 32'h0);
        @(negedge pclk);
        preset = 1'b0;
        cfg_waits = 0;
        @(negedge pclk);
        chk("t4_no_rsp", 32'(bus.rsp_valid), 32'h0);

        // All sources requesting continuously: grants 0,1,2,3,0,... every 3 cycles
        cfg_rdata = 32'hCAFE_0000;
        for (int s = 0; s < NR; s++) begin
            bus.cmd_write[s]         = s[0];
            bus.cmd_addr[s*AW +: AW] = 32'h1000 + 32'(s * 4);
            bus.cmd_wdata[s*DW +: DW] = 32'h5000_0000 + 32'(s);
            bus.cmd_strb[s*4 +: 4]   = 4'hF;
            bus.cmd_prot[s*3 +: 3]   = 3'b000;
        end
        bus.cmd_valid = '1;
        acc_n  = 0;
        last_c = 0;
        for (int c = 0; c < 60 && acc_n < 8; c++) begin
            #1;
            if (bus.cmd_ready != '0) begin
                chk("rr_grant", 32'(bus.cmd_ready), 32'(1) << (acc_n % NR));
                if (acc_n > 0) chk("rr_interval", 32'(c - last_c), 32'd3);
                e.hot    = NR'(1 << (acc_n % NR));
                e.rdata  = ((acc_n % 2) == 1) ? 32'h0 : 32'hCAFE_0000;
                e.slverr = 1'b0;
                exp_q.push_back(e);
                $display("rr   accept #%0d hot=%b t=%0t", acc_n, bus.cmd_ready, $time);
                last_c = c;
                acc_n++;
            end
            @(negedge pclk);
        end
        bus.cmd_valid = '0;
        chk("rr_count", 32'(acc_n), 32'd8);
        repeat (6) @(negedge pclk);

`ifdef APB_ARB_TIMEOUT_EN
        // Completer never answers: abort after 4 ACCESS cycles with slverr
        cfg_waits = 1000; cfg_rdata = 32'h7777_7777;
        issue(0, 1'b0, 32'h300, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b1);
        count_access(n_acc);
        chk("to_access_cycles", 32'(n_acc), 32'd4);
        cfg_waits = 0;
        repeat (3) @(negedge pclk);
`endif

        repeat (5) @(negedge pclk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end
endmodule
